// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register driving the EX-stage ALU operands, ALU control and load-use flag.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding; otherwise latched register data is used.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] id_pc4,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [5:0]       id_funct,
    input  logic [8:0]       id_ctrl,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctr,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_write_reg,
    output logic [6:0]       ex_ctrl,
    output logic [WIDTH-1:0] ex_pc4,
    output logic [WIDTH-1:0] ex_imm,
    output logic             load_use
);
    logic [WIDTH-1:0] r_pc4, r_rs_data, r_rt_data, r_imm;
    logic [4:0]       r_rs, r_rt, r_rd;
    logic [5:0]       r_funct;
    logic [8:0]       r_ctrl;
    logic [WIDTH-1:0] w_fwd_rs, w_fwd_rt;
    logic [2:0]       w_funct_ctr;
    logic [1:0]       w_alu_op;
    logic             w_mem_read, w_reg_dst, w_alu_src;

    // A flush zeroes the control word, so the bubble never writes registers or memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_funct   <= '0;
            r_ctrl    <= '0;
        end else if (!stall) begin
            r_pc4     <= id_pc4;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_funct   <= id_funct;
            r_ctrl    <= id_ctrl;
        end
    end

    assign w_mem_read = r_ctrl[6];
    assign w_reg_dst  = r_ctrl[3];
    assign w_alu_src  = r_ctrl[2];
    assign w_alu_op   = r_ctrl[1:0];

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger result, so it is checked first; r0 is hardwired and never forwarded.
    assign w_fwd_rs = (mem_reg_write && mem_rd != 5'd0 && mem_rd == r_rs) ? mem_result :
                      (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == r_rs) ? wb_result  : r_rs_data;
    assign w_fwd_rt = (mem_reg_write && mem_rd != 5'd0 && mem_rd == r_rt) ? mem_result :
                      (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == r_rt) ? wb_result  : r_rt_data;
`else
    logic w_unused;
    assign w_unused = ^{mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result};
    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;
`endif

    assign w_funct_ctr = (r_funct == 6'b100000) ? 3'b000 :
                         (r_funct == 6'b100010) ? 3'b001 :
                         (r_funct == 6'b100100) ? 3'b010 :
                         (r_funct == 6'b100101) ? 3'b011 :
                         (r_funct == 6'b101010) ? 3'b100 : 3'b000;

    assign alu_ctr = (w_alu_op == 2'b00) ? 3'b000 :
                     (w_alu_op == 2'b01) ? 3'b001 :
                     (w_alu_op == 2'b11) ? 3'b011 : w_funct_ctr;

    assign alu_a         = w_fwd_rs;
    assign alu_b         = w_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_write_reg  = w_reg_dst ? r_rd : r_rt;
    assign ex_ctrl       = r_ctrl[8:2];
    assign ex_pc4        = r_pc4;
    assign ex_imm        = r_imm;
    assign load_use      = w_mem_read && r_rt != 5'd0 && (r_rt == id_rs || r_rt == id_rt);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expectations follow the ID_EX_FWD_EN setting of the build.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a, b, sd, pc4, imm;
        logic [2:0]  ctr;
        logic [4:0]  wr;
        logic [6:0]  ctrl;
        logic        lu;
    } out_t;

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
    logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [5:0]  id_funct = '0;
    logic [8:0]  id_ctrl = '0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_rd = '0, wb_rd = '0;
    logic [31:0] mem_result = '0, wb_result = '0;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc4, ex_imm;
    logic [2:0]  alu_ctr;
    logic [4:0]  ex_write_reg;
    logic [6:0]  ex_ctrl;
    logic        load_use;

    out_t sb[$];
    out_t exp_o, obs;
    int   tests = 0, failed = 0;

    id_ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_imm(ex_imm),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    function automatic out_t snap();
        return '{alu_a, alu_b, ex_store_data, ex_pc4, ex_imm, alu_ctr, ex_write_reg, ex_ctrl, load_use};
    endfunction

    function automatic out_t mk(input logic [31:0] a, b, sd, pc4, imm, input logic [2:0] ctr,
                                input logic [4:0] wr, input logic [6:0] ctrl, input logic lu);
        return '{a, b, sd, pc4, imm, ctr, wr, ctrl, lu};
    endfunction

    task automatic drive_id(input logic [31:0] pc4, rs_d, rt_d, imm, input logic [4:0] rs, rt, rd,
                            input logic [5:0] fn, input logic [8:0] ctrl);
        id_pc4 = pc4; id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_funct = fn; id_ctrl = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b0;
        drive_id(32'h44, 32'h5, 32'h9, 32'h7, 5'd1, 5'd2, 5'd3, 6'b101010, {7'b1000010, 2'b10});
        tick();
        #2 reset = 1'b1;
        sb.push_back('0);
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL reset_async: got %h exp %h", obs, exp_o); end
        sb.push_back('0);
        tick();
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL reset_hold: got %h exp %h", obs, exp_o); end
        reset = 1'b0;
    endtask

    task automatic test_decode();
        logic [1:0] ops [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
        logic [5:0] fns [9] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000,
                                6'b101010, 6'b101010, 6'b101010};
        logic [2:0] ctrs[9] = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b000, 3'b001, 3'b011};
        for (int i = 0; i < 9; i++) begin
            drive_id(32'h400 + 32'(i * 4), 32'd5, 32'd9, 32'(i), 5'd1, 5'd2, 5'd3, fns[i],
                     {7'b1000010, ops[i]});
            sb.push_back(mk(32'd5, 32'd9, 32'd9, 32'h400 + 32'(i * 4), 32'(i), ctrs[i], 5'd3,
                            7'b1000010, 1'b0));
            tick();
            exp_o = sb.pop_front(); obs = snap(); tests++;
            if (obs !== exp_o) begin failed++; $display("FAIL decode[%0d]: got %h exp %h", i, obs, exp_o); end
        end
    endtask

    task automatic test_alusrc_regdst();
        drive_id(32'h600, 32'h10, 32'h77, 32'hFFFF_FFFC, 5'd6, 5'd7, 5'd12, 6'b100010,
                 {7'b0001001, 2'b00});
        sb.push_back(mk(32'h10, 32'hFFFF_FFFC, 32'h77, 32'h600, 32'hFFFF_FFFC, 3'b000, 5'd7,
                        7'b0001001, 1'b0));
        tick();
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL alusrc_regdst: got %h exp %h", obs, exp_o); end
    endtask

    task automatic test_forward();
        drive_id(32'h700, 32'hAA, 32'hBB, 32'h0, 5'd3, 5'd5, 5'd6, 6'b100000, {7'b1000010, 2'b10});
        tick();
        stall = 1'b1;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h22;
        sb.push_back(mk(FWD ? 32'h11 : 32'hAA, 32'hBB, 32'hBB, 32'h700, 32'h0, 3'b000, 5'd6, 7'b1000010, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL fwd_mem_wins: got %h exp %h", obs, exp_o); end
        mem_reg_write = 1'b0;
        sb.push_back(mk(FWD ? 32'h22 : 32'hAA, 32'hBB, 32'hBB, 32'h700, 32'h0, 3'b000, 5'd6, 7'b1000010, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL fwd_wb: got %h exp %h", obs, exp_o); end
        wb_rd = 5'd5;
        sb.push_back(mk(32'hAA, FWD ? 32'h22 : 32'hBB, FWD ? 32'h22 : 32'hBB, 32'h700, 32'h0, 3'b000,
                        5'd6, 7'b1000010, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL fwd_rt_wb: got %h exp %h", obs, exp_o); end
        mem_reg_write = 1'b1; mem_rd = 5'd5;
        sb.push_back(mk(32'hAA, FWD ? 32'h11 : 32'hBB, FWD ? 32'h11 : 32'hBB, 32'h700, 32'h0, 3'b000,
                        5'd6, 7'b1000010, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL fwd_rt_mem: got %h exp %h", obs, exp_o); end
        stall = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        drive_id(32'h704, 32'hCC, 32'hBB, 32'h0, 5'd0, 5'd5, 5'd6, 6'b100000, {7'b1000010, 2'b10});
        tick();
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_reg_write = 1'b1; wb_rd = 5'd0;
        sb.push_back(mk(32'hCC, 32'hBB, 32'hBB, 32'h704, 32'h0, 3'b000, 5'd6, 7'b1000010, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL fwd_r0: got %h exp %h", obs, exp_o); end
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic test_load_use();
        logic [4:0] rs_l[3] = '{5'd4, 5'd1, 5'd1};
        logic [4:0] rt_l[3] = '{5'd9, 5'd4, 5'd9};
        logic       lu_l[3] = '{1'b1, 1'b1, 1'b0};
        drive_id(32'h500, 32'h100, 32'h200, 32'h8, 5'd2, 5'd4, 5'd0, 6'b0, 9'b111000100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_id(32'h504, 32'h1, 32'h2, 32'h3, rs_l[i], rt_l[i], 5'd10, 6'b100000, {7'b1000010, 2'b10});
            sb.push_back(mk(32'h100, 32'h8, 32'h200, 32'h500, 32'h8, 3'b000, 5'd4, 7'b1110001, lu_l[i]));
            #1;
            exp_o = sb.pop_front(); obs = snap(); tests++;
            if (obs !== exp_o) begin failed++; $display("FAIL load_use[%0d]: got %h exp %h", i, obs, exp_o); end
        end
        id_rs = 5'd4;
        flush = 1'b1;
        sb.push_back('0);
        tick();
        flush = 1'b0;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL lu_bubble: got %h exp %h", obs, exp_o); end
        drive_id(32'h508, 32'h100, 32'h200, 32'h8, 5'd2, 5'd0, 5'd0, 6'b0, 9'b111000100);
        tick();
        id_rs = 5'd0; id_rt = 5'd0;
        sb.push_back(mk(32'h100, 32'h8, 32'h200, 32'h508, 32'h8, 3'b000, 5'd0, 7'b1110001, 1'b0));
        #1;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL lu_rt0: got %h exp %h", obs, exp_o); end
    endtask

    task automatic test_stall_flush();
        drive_id(32'h800, 32'h1234, 32'h5678, 32'h1, 5'd1, 5'd2, 5'd3, 6'b100010, {7'b1000010, 2'b10});
        tick();
        stall = 1'b1;
        drive_id(32'h804, 32'hDEAD, 32'hBEEF, 32'h2, 5'd7, 5'd8, 5'd9, 6'b100100, {7'b1000010, 2'b10});
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(32'h1234, 32'h5678, 32'h5678, 32'h800, 32'h1, 3'b001, 5'd3, 7'b1000010, 1'b0));
            tick();
            exp_o = sb.pop_front(); obs = snap(); tests++;
            if (obs !== exp_o) begin failed++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, obs, exp_o); end
        end
        flush = 1'b1;
        sb.push_back('0);
        tick();
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL stall_flush: got %h exp %h", obs, exp_o); end
        stall = 1'b0; flush = 1'b0;
        sb.push_back(mk(32'hDEAD, 32'hBEEF, 32'hBEEF, 32'h804, 32'h2, 3'b010, 5'd9, 7'b1000010, 1'b0));
        tick();
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL resume: got %h exp %h", obs, exp_o); end
        flush = 1'b1;
        sb.push_back('0);
        tick();
        flush = 1'b0;
        exp_o = sb.pop_front(); obs = snap(); tests++;
        if (obs !== exp_o) begin failed++; $display("FAIL flush: got %h exp %h", obs, exp_o); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alusrc_regdst();
        test_forward();
        test_load_use();
        test_stall_flush();
        tests++;
        if (sb.size() != 0) begin failed++; $display("FAIL sb_drain: got %0d left exp 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
